// File: rtl/accumulator_pkg.sv
// rtl/accumulator_pkg.sv - shared bus opcodes and arbiter FSM encodings
package accumulator_pkg;

  localparam int NPROC_DEF = 4;
  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 6;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_SEND  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_OP,
    ST_RESP,
    ST_RELEASE
  } mem_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr_i
module rr_arbiter #(
  parameter int NPROC = 4,
  parameter int PW    = 2
) (
  input  logic [NPROC-1:0] req_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic [NPROC-1:0] grant_o,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 0; i < NPROC; i++) begin
      j = int'(rr_ptr_i) + i;
      if (j >= NPROC) j = j - NPROC;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/accumulator_memory.sv
// rtl/accumulator_memory.sv - operand FIFO and round-robin bus owner for the accumulator processors
module accumulator_memory
  import accumulator_pkg::*;
#(
  parameter int NPROC = NPROC_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NPROC-1:0] req,
  output logic [NPROC-1:0] grant,
  input  logic [1:0]       op,
  output logic [31:0]      read,
  input  logic [31:0]      write,
  output logic             signal,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  output logic [AW:0]      count,
  output logic             done,
  output logic             overflow
);

  localparam int PW = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW+1:0] IF_ONE   = (AW+2)'(1);
  localparam logic [AW+1:0] IF_TWO   = (AW+2)'(2);

  mem_state_e       state_q, state_d;
  logic [NPROC-1:0] grant_q, grant_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [AW+1:0]    in_flight_q, in_flight_d;
  logic [31:0]      read_q, read_d;
  logic             signal_q, signal_d;
  logic             overflow_q, overflow_d;
  logic             done_q;

  logic             push, pop, full, mem_we;
  logic [31:0]      push_data;
  logic [31:0]      mem_q [DEPTH];

  logic [NPROC-1:0] arb_grant;
  logic [PW-1:0]    arb_idx;
  logic             arb_valid;

  rr_arbiter #(.NPROC(NPROC), .PW(PW)) u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  assign full   = (count_q == FULL_CNT);
  assign mem_we = push && !full;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    in_flight_d = in_flight_q;
    read_d      = read_q;
    signal_d    = signal_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    pop         = 1'b0;
    push_data   = write;

    case (state_q)
      ST_IDLE: begin
        if (load_valid && grant_q == '0) begin
          push      = 1'b1;
          push_data = load_data;
        end else if (arb_valid) begin
          grant_d = arb_grant;
          owner_d = arb_idx;
          state_d = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (!req[owner_q]) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          // x/z opcodes match no item and fall through as NOP
          case (op)
            OP_FETCH: begin
              if (count_q != '0) begin
                read_d      = mem_q[head_q];
                signal_d    = 1'b1;
                pop         = 1'b1;
                in_flight_d = in_flight_q + IF_ONE;
                state_d     = ST_RESP;
              end
            end
            OP_SEND: begin
              push        = 1'b1;
              signal_d    = 1'b1;
              in_flight_d = (in_flight_q >= IF_TWO) ? in_flight_q - IF_TWO : '0;
              state_d     = ST_RESP;
            end
            default: ;
          endcase
        end
      end
      ST_RESP: begin
        signal_d = 1'b0;
        grant_d  = '0;
        rr_ptr_d = (owner_q == PW'(NPROC-1)) ? '0 : owner_q + PW'(1);
        state_d  = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!req[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // a push into a full FIFO is dropped but still completes on the bus
    if (push) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        tail_d  = tail_q + AW'(1);
        count_d = count_q + ONE_CNT;
      end
    end
    if (pop) begin
      head_d  = head_q + AW'(1);
      count_d = count_q - ONE_CNT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      read_q      <= '0;
      signal_q    <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      read_q      <= read_d;
      signal_q    <= signal_d;
      overflow_q  <= overflow_d;
      done_q      <= (count_d == ONE_CNT) && (in_flight_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tail_q] <= push_data;
  end

  assign grant    = grant_q;
  assign read     = read_q;
  assign signal   = signal_q;
  assign count    = count_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_accumulator_memory.sv
// tb/tb_accumulator_memory.sv - directed bench with a queue-based model of the operand store
module tb_accumulator_memory;
  import accumulator_pkg::*;

  localparam int NP  = 4;
  localparam int DP  = 64;
  localparam int AWB = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] req;
  logic [NP-1:0] grant;
  logic [1:0]    op;
  logic [31:0]   rdata, wdata, load_data;
  logic          sig, load_valid, done, overflow;
  logic [AWB:0]  count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] mq[$];
  int          m_inflight = 0;
  bit          m_ovf = 1'b0;
  bit          m_read_valid = 1'b0;
  logic [31:0] m_last_read = '0;
  int          sig_cnt = 0;

  accumulator_memory #(.NPROC(NP), .DEPTH(DP), .AW(AWB)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req        (req),
    .grant      (grant),
    .op         (op),
    .read       (rdata),
    .write      (wdata),
    .signal     (sig),
    .load_valid (load_valid),
    .load_data  (load_data),
    .count      (count),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (sig === 1'b1) sig_cnt++;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        chk("count", 64'(count), 64'(mq.size()));
        chk("done", 64'(done), 64'((mq.size() == 1 && m_inflight == 0) ? 1 : 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("grant_onehot", 64'($countones(grant) <= 1), 64'(1));
        if (m_read_valid) chk("read", 64'(rdata), 64'(m_last_read));
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    m_inflight   = 0;
    m_ovf        = 1'b0;
    m_read_valid = 1'b0;
  endtask

  task automatic do_reset();
    chk_en     = 1'b0;
    rst_n      = 1'b0;
    req        = '0;
    op         = OP_NOP;
    wdata      = '0;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic load(input logic [31:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
    if (mq.size() == DP) m_ovf = 1'b1;
    else mq.push_back(d);
  endtask

  task automatic serve(input logic [1:0] o, input logic [31:0] wd, input bit keep,
                       output int idx, output logic [31:0] rd);
    int n;
    idx = 0;
    rd  = '0;
    n   = 0;
    @(negedge clk);
    while (grant == '0 && n < 50) begin @(negedge clk); n++; end
    if (grant == '0) begin chk("grant_timeout", 0, 1); req = '0; return; end
    for (int i = 0; i < NP; i++) if (grant[i]) idx = i;
    op    = o;
    wdata = wd;
    n     = 0;
    @(negedge clk);
    while (sig !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (sig !== 1'b1) begin chk("signal_timeout", 0, 1); op = OP_NOP; req = '0; return; end
    rd = rdata;
    if (o == OP_FETCH) begin
      m_last_read  = mq.pop_front();
      m_inflight++;
      m_read_valid = 1'b1;
    end else begin
      if (mq.size() == DP) m_ovf = 1'b1;
      else mq.push_back(wd);
      m_inflight = (m_inflight >= 2) ? m_inflight - 2 : 0;
    end
    op       = OP_NOP;
    req[idx] = 1'b0;
    @(negedge clk);
    m_read_valid = 1'b0;
    @(negedge clk);
    if (keep) req[idx] = 1'b1;
  endtask

  task automatic bus_op(input int p, input logic [1:0] o, input logic [31:0] wd,
                        output logic [31:0] rd);
    int idx;
    req[p] = 1'b1;
    serve(o, wd, 1'b0, idx, rd);
  endtask

  initial begin
    logic [31:0] rd, a, b;
    int idx, n, s0;

    rst_n = 1'b0; req = '0; op = OP_NOP; wdata = '0; load_valid = 1'b0; load_data = '0;
    @(negedge clk);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_signal", 64'(sig), 0);
    chk("rst_read", 64'(rdata), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_overflow", 64'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    load(32'd3);
    load(32'd5);
    bus_op(0, OP_FETCH, 0, rd);
    chk("fetch_first", 64'(rd), 3);
    bus_op(0, OP_FETCH, 0, rd);
    chk("fetch_second", 64'(rd), 5);
    chk("count_empty", 64'(count), 0);
    bus_op(0, OP_SEND, 32'd8, rd);
    chk("count_after_send", 64'(count), 1);
    chk("done_after_send", 64'(done), 1);
    bus_op(0, OP_FETCH, 0, rd);
    chk("fetch_sum", 64'(rd), 8);
    chk("done_cleared", 64'(done), 0);

    req[1] = 1'b1;
    @(negedge clk);
    chk("stall_granted", 64'(grant), 64'(4'b0010));
    op = OP_FETCH;
    repeat (5) begin
      @(negedge clk);
      chk("stall_signal", 64'(sig), 0);
      chk("stall_grant", 64'(grant), 64'(4'b0010));
    end
    req[1] = 1'b0;
    op     = OP_NOP;
    @(negedge clk);
    chk("abort_grant", 64'(grant), 0);
    chk("abort_count", 64'(count), 0);
    @(negedge clk);

    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(OP_SEND, 32'(20 + k), (k < 4), idx, rd);
      chk("rr_order", 64'(idx), 64'(k % 4));
    end
    req = '0;
    repeat (2) @(negedge clk);
    chk("rr_count", 64'(count), 5);

    do_reset();
    for (int i = 0; i < DP; i++) load(32'(100 + i));
    chk("full_count", 64'(count), 64);
    s0 = sig_cnt;
    bus_op(3, OP_SEND, 32'd1, rd);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_count", 64'(count), 64);
    chk("ovf_pulses", 64'(sig_cnt - s0), 1);
    bus_op(0, OP_FETCH, 0, rd);
    chk("fetch_after_full", 64'(rd), 100);

    chk_en = 1'b0;
    req[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (grant[2] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("resp_grant_seen", 64'(grant[2]), 1);
    op    = OP_SEND;
    wdata = 32'd77;
    n     = 0;
    @(negedge clk);
    while (sig !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("resp_signal_seen", 64'(sig), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 64'(grant), 0);
    chk("midrst_signal", 64'(sig), 0);
    chk("midrst_read", 64'(rdata), 0);
    chk("midrst_count", 64'(count), 0);
    chk("midrst_done", 64'(done), 0);
    chk("midrst_overflow", 64'(overflow), 0);
    req = '0;
    op  = OP_NOP;
    @(negedge clk);
    do_reset();

    for (int v = 1; v <= 16; v++) load(32'(v));
    for (int r = 0; r < 15; r++) begin
      bus_op(r % 4, OP_FETCH, 0, a);
      bus_op(r % 4, OP_FETCH, 0, b);
      bus_op(r % 4, OP_SEND, a + b, rd);
    end
    chk("sys_done", 64'(done), 1);
    chk("sys_count", 64'(count), 1);
    bus_op(0, OP_FETCH, 0, rd);
    chk("sys_final", 64'(rd), 136);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
